// File: rtl/shmem_arb_pkg.sv
// Shared types and constants for the shared-memory round-robin arbiter.
package shmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // addr[31:7] of the shared word region (byte addresses 128-255)
    localparam logic [24:0] SHMEM_BASE    = 25'd1;
    localparam int          DEF_NUM_CORES = 4;
    localparam int          DEF_LOCK_MAX  = 16;
    localparam int          CNT_W         = 16;
    localparam int          ID_W          = 3;

endpackage

// File: rtl/shmem_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above
// start, wrapping modulo N.
module rr_pick
    import shmem_arb_pkg::*;
#(
    parameter int N = DEF_NUM_CORES
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    // Scan from the far end so the closest requester to start wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[SEL_W'((int'(start) + k) % N)]) begin
                idx   = ID_W'((int'(start) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shmem_arbiter.sv
// Round-robin arbiter for the single-port shared data memory.
// Optional bus locking is built when SHMEM_ARB_LOCK_EN is defined.
module shmem_arbiter
    import shmem_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int LOCK_MAX  = DEF_LOCK_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CORES-1:0]   core_req,
    input  logic [NUM_CORES-1:0]   core_we,
    input  logic [32*NUM_CORES-1:0] core_addr,
    input  logic [32*NUM_CORES-1:0] core_wdata,
    input  logic [NUM_CORES-1:0]   core_lock,
    output logic [NUM_CORES-1:0]   core_stall,
    output logic [31:0]            core_rdata,
    output logic [ID_W-1:0]        grant_id,
    output logic                   grant_vld,
    output logic [31:0]            mem_addr,
    output logic                   mem_we,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    output logic [CNT_W-1:0]       conflict_cnt,
    output logic                   lock_timeout,
    output arb_state_t             dbg_state
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick_idx;
    logic            pick_vld;

    rr_pick #(.N(NUM_CORES)) u_pick (
        .req   (core_req),
        .start (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_CORES - 1)) ? '0 : id + ID_W'(1);
    endfunction

`ifdef SHMEM_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t      state;
    logic [ID_W-1:0] lock_owner;
    logic [LCNT_W-1:0] lock_cnt;
    logic            owner_req;
    logic            owner_lock;
    logic            g_lock;

    always_comb begin
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        g_lock     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (lock_owner == ID_W'(i)) begin
                owner_req  = core_req[i];
                owner_lock = core_lock[i];
            end
            if (grant_vld && grant_id == ID_W'(i)) g_lock = core_lock[i];
        end
    end

    assign dbg_state = state;
`else
    logic unused_lock;
    assign unused_lock  = (^core_lock) ^ (LOCK_MAX > 0);
    assign lock_timeout = 1'b0;
    assign dbg_state    = IDLE;
`endif

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (!reset) begin
`ifdef SHMEM_ARB_LOCK_EN
            if (state == LOCKED) begin
                grant_vld = owner_req;
                grant_id  = owner_req ? lock_owner : '0;
            end else begin
                grant_vld = pick_vld;
                grant_id  = pick_idx;
            end
`else
            grant_vld = pick_vld;
            grant_id  = pick_idx;
`endif
        end
    end

    // Forward the granted core's access; everything reads 0 without a grant.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        core_stall = core_req;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_vld && grant_id == ID_W'(i)) begin
                mem_addr      = core_addr[32*i +: 32];
                mem_wdata     = core_wdata[32*i +: 32];
                mem_we        = core_we[i];
                core_stall[i] = 1'b0;
            end
        end
    end

    assign core_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            conflict_cnt <= '0;
`ifdef SHMEM_ARB_LOCK_EN
            state        <= IDLE;
            lock_owner   <= '0;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
`endif
        end else begin
            if ($countones(core_req) >= 2 && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            if (grant_vld)
                rr_ptr <= next_id(grant_id);
`ifdef SHMEM_ARB_LOCK_EN
            lock_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld && g_lock) begin
                        state      <= LOCKED;
                        lock_owner <= grant_id;
                        lock_cnt   <= LCNT_W'(1);
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt + LCNT_W'(1);
                    // Release on owner dropping the lock, or force it at LOCK_MAX.
                    if (!owner_lock || lock_cnt == LCNT_W'(LOCK_MAX)) begin
                        state        <= IDLE;
                        lock_cnt     <= '0;
                        rr_ptr       <= next_id(lock_owner);
                        lock_timeout <= owner_lock;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_shmem_arbiter.sv
// Self-checking bench for shmem_arbiter: directed steps plus random traffic
// checked against a rule-level model of round-robin grant and bus locking.
module tb_shmem_arbiter;
    import shmem_arb_pkg::*;

    localparam int N    = 4;
    localparam int LMAX = 16;
`ifdef SHMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [N-1:0]   core_req;
    logic [N-1:0]   core_we;
    logic [32*N-1:0] core_addr;
    logic [32*N-1:0] core_wdata;
    logic [N-1:0]   core_lock;
    logic [N-1:0]   core_stall;
    logic [31:0]    core_rdata;
    logic [2:0]     grant_id;
    logic           grant_vld;
    logic [31:0]    mem_addr;
    logic           mem_we;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;
    logic [15:0]    conflict_cnt;
    logic           lock_timeout;
    arb_state_t     dbg_state;

    logic [31:0] addr_a [N];
    logic [31:0] wd_a   [N];

    shmem_arbiter #(.NUM_CORES(N), .LOCK_MAX(LMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_lock    (core_lock),
        .core_stall   (core_stall),
        .core_rdata   (core_rdata),
        .grant_id     (grant_id),
        .grant_vld    (grant_vld),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt),
        .lock_timeout (lock_timeout),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        core_addr  = '0;
        core_wdata = '0;
        for (int i = 0; i < N; i++) begin
            core_addr[32*i +: 32]  = addr_a[i];
            core_wdata[32*i +: 32] = wd_a[i];
        end
    end

    // Shared memory: combinational read, store commits at the clock edge
    logic [31:0] shmem [0:31];
    assign mem_rdata = shmem[mem_addr[6:2]];
    always @(posedge clk) if (mem_we) shmem[mem_addr[6:2]] <= mem_wdata;

    // Scoreboard
    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    // Reference model state
    int m_start  = 0;
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_held   = 0;
    int m_conf   = 0;
    bit m_tout   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(output bit gv, output int gid);
        gv  = 1'b0;
        gid = 0;
        if (reset) return;
        if (m_locked) begin
            gv  = core_req[m_owner];
            gid = gv ? m_owner : 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_start + k) % N;
            if (core_req[i]) begin
                gv  = 1'b1;
                gid = i;
                break;
            end
        end
    endtask

    task automatic model_update(input bit gv, input int gid);
        bit tnext;
        tnext = 1'b0;
        if (reset) begin
            m_start = 0; m_locked = 1'b0; m_owner = 0; m_held = 0; m_conf = 0; m_tout = 1'b0;
            return;
        end
        if ($countones(core_req) >= 2 && m_conf < 65535) m_conf++;
        if (gv) m_start = (gid + 1) % N;
        if (m_locked) begin
            m_held++;
            if (!core_lock[m_owner]) begin
                m_locked = 1'b0;
                m_start  = (m_owner + 1) % N;
            end else if (m_held == LMAX) begin
                m_locked = 1'b0;
                m_start  = (m_owner + 1) % N;
                tnext    = 1'b1;
            end
        end else if (LOCK_EN && gv && core_lock[gid]) begin
            m_locked = 1'b1;
            m_owner  = gid;
            m_held   = 0;
        end
        m_tout = tnext;
    endtask

    // Driver: inputs are set by the caller after a falling edge; this checks
    // the outputs, advances the model, and returns at the next falling edge.
    task automatic cycle(input bit check);
        bit gv;
        int gid;
        logic [N-1:0] stall_e;
        #2;
        model_grant(gv, gid);
        stall_e = core_req;
        if (gv) stall_e[gid] = 1'b0;
        if (check) begin
            chk("grant_vld", grant_vld, gv);
            chk("grant_id", grant_id, gid);
            chk("core_stall", core_stall, stall_e);
            chk("mem_we", mem_we, gv && core_we[gid]);
            chk("mem_addr", mem_addr, gv ? addr_a[gid] : 32'd0);
            chk("mem_wdata", mem_wdata, gv ? wd_a[gid] : 32'd0);
            chk("conflict_cnt", conflict_cnt, m_conf);
            chk("lock_timeout", lock_timeout, m_tout);
        end
        model_update(gv, gid);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [N-1:0] req, input logic [N-1:0] we, input logic [N-1:0] lock);
        core_req  = req;
        core_we   = we;
        core_lock = lock;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shmem[i] = '0;
        reset = 1'b1;
        set_req('0, '0, '0);
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 32'd128 + 32'(4 * i);
            wd_a[i]   = 32'h100 + 32'(i);
        end
        @(posedge clk);
        @(negedge clk);

        // Reset with all cores requesting
        set_req(4'b1111, '0, '0);
        #1;
        chk("rst_grant_vld", grant_vld, 1'b0);
        chk("rst_stall", core_stall, 4'b1111);
        cycle(1);
        cycle(1);

        // Release: grants go 0,1,2,3
        reset = 1'b0;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        exp_q.push_back(3'd2); exp_q.push_back(3'd3);
        repeat (4) begin
            #1;
            chk("rr_order", grant_id, exp_q.pop_front());
            cycle(1);
        end

        // Core 1 stores 50 at 128, core 2 loads it back
        set_req(4'b0010, 4'b0010, '0);
        addr_a[1] = 32'd128;
        wd_a[1]   = 32'd50;
        #1;
        chk("sw_we", mem_we, 1'b1);
        chk("sw_wdata", mem_wdata, 32'd50);
        cycle(1);
        set_req(4'b0100, '0, '0);
        addr_a[2] = 32'd128;
        #1;
        chk("lw_rdata", core_rdata, 32'd50);
        chk("lw_stall2", core_stall[2], 1'b0);
        cycle(1);

        // Cores 0 and 3 with the pointer at 1 alternate 3,0,3,0
        set_req(4'b0001, '0, '0);
        cycle(1);
        set_req(4'b1001, '0, '0);
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        repeat (4) begin
            #1;
            chk("alt_03", grant_id, exp_q.pop_front());
            cycle(1);
        end

`ifdef SHMEM_ARB_LOCK_EN
        // Core 2 holds the bus while core 0 waits
        set_req(4'b0010, '0, '0);
        cycle(1);
        exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd2);
        for (int c = 0; c < 3; c++) begin
            set_req(4'b0101, '0, (c < 2) ? 4'b0100 : 4'b0000);
            #1;
            chk("lock_grant", grant_id, exp_q.pop_front());
            chk("lock_stall0", core_stall[0], 1'b1);
            cycle(1);
        end
        set_req(4'b0001, '0, '0);
        #1;
        chk("unlock_grant0", grant_id, 3'd0);
        cycle(1);

        // Core 1 never releases: forced release after LOCK_MAX locked cycles
        set_req(4'b0110, '0, 4'b0010);
        repeat (LMAX + 1) begin
            #1;
            chk("tmo_hold", grant_id, 3'd1);
            cycle(1);
        end
        #1;
        chk("tmo_pulse", lock_timeout, 1'b1);
        chk("tmo_next", grant_id, 3'd2);
        cycle(1);
        set_req(4'b0110, '0, '0);
        #1;
        chk("tmo_pulse_end", lock_timeout, 1'b0);
        cycle(1);

        // Reset in the middle of a lock drops it
        set_req(4'b0010, '0, 4'b0010);
        cycle(1);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        set_req(4'b0101, '0, '0);
        #1;
        chk("rst_unlock", grant_id, 3'd0);
        cycle(1);
`endif

        // Random traffic
        repeat (400) begin
            reset = ($urandom_range(0, 49) == 0);
            core_req = N'($urandom_range(0, 15));
            core_we  = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                core_lock[i] = ($urandom_range(0, 3) == 0);
                addr_a[i] = 32'd128 + 32'(4 * $urandom_range(0, 31))
                          + (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
                wd_a[i]   = $urandom;
            end
            cycle(1);
        end

        // Conflict counter saturation
        reset = 1'b1;
        set_req('0, '0, '0);
        cycle(1);
        reset = 1'b0;
        set_req(4'b0011, '0, '0);
        repeat (65534) cycle(0);
        #1;
        chk("conf_fffe", conflict_cnt, 32'h0000FFFE);
        repeat (3) cycle(1);
        #1;
        chk("conf_sat", conflict_cnt, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
